// File: rtl/l1i_refill_engine.sv
// l1i_refill_engine: L1I miss refill FSM; one memory read per miss, line streamed into the cache lowest beat first
module l1i_refill_engine #(
  parameter int B = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        L1IMiss,
  input  logic [31:0] Address,
  output logic        RepReady,
  output logic [63:0] RepWord,
  output logic        RefillBusy,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic        MemRdValid,
  input  logic [63:0] MemRdData
);
  localparam int BEATS = B / 8;
  localparam int b = $clog2(B);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  typedef enum logic [2:0] {IDLE, REQ, FILL, STREAM, SETTLE} stateT;
  stateT state;
  logic [CW-1:0] beatCnt, rdPtr;
  logic [63:0] lineBuf [BEATS];
  logic unusedAddr;
  assign unusedAddr = ^Address[b-1:0];
  // RepReady is registered, so the word mux only sees registered state
  assign RepWord = RepReady ? lineBuf[rdPtr] : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      beatCnt <= '0;
      rdPtr <= '0;
      RepReady <= 1'b0;
      MemReq <= 1'b0;
      MemAddr <= '0;
      RefillBusy <= 1'b0;
    end else
      case (state)
        IDLE: if (L1IMiss) begin
          state <= REQ;
          MemReq <= 1'b1;
          MemAddr <= {Address[31:b], {b{1'b0}}};
          RefillBusy <= 1'b1;
        end
        REQ: if (MemAck) begin
          state <= FILL;
          MemReq <= 1'b0;
          MemAddr <= '0;
          beatCnt <= '0;
        end
        FILL: if (MemRdValid) begin
          beatCnt <= beatCnt == LAST ? '0 : beatCnt + 1'b1;
          if (beatCnt == LAST) begin
            state <= STREAM;
            rdPtr <= '0;
            RepReady <= 1'b1;
          end
        end
        STREAM: begin
          rdPtr <= rdPtr == LAST ? '0 : rdPtr + 1'b1;
          if (rdPtr == LAST) begin
            state <= SETTLE;
            RepReady <= 1'b0;
          end
        end
        SETTLE: begin
          state <= IDLE;
          RefillBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk)
    if (state == FILL && MemRdValid) lineBuf[beatCnt] <= MemRdData;
endmodule

// File: tb/tb_l1i_refill_engine.sv
// tb_l1i_refill_engine: scoreboard bench for the L1I refill engine
module tb_l1i_refill_engine;
  localparam int B = 64;
  localparam int BEATS = B / 8;
  logic clk = 0, reset = 0, L1IMiss = 0, MemAck = 0, MemRdValid = 0;
  logic [31:0] Address = '0;
  logic [63:0] MemRdData = '0;
  logic RepReady, RefillBusy, MemReq;
  logic [63:0] RepWord;
  logic [31:0] MemAddr;
  int tests = 0, fails = 0;
  logic [63:0] expQ[$], obsQ[$];
  logic [15:0] repTr, busyTr, reqTr;
  int reqCyc;
  logic [31:0] reqAddr;
  bit addrOk, spurious;
  logic [98:0] rstOuts;

  l1i_refill_engine #(.B(B)) dut (
    .clk(clk), .reset(reset), .L1IMiss(L1IMiss), .Address(Address),
    .RepReady(RepReady), .RepWord(RepWord), .RefillBusy(RefillBusy),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .MemRdValid(MemRdValid), .MemRdData(MemRdData)
  );

  always #5 clk = ~clk;

  task automatic refill(input logic [31:0] addr, input int ackDly, input bit gapped, input bit hold,
                        input logic [31:0] churn, input int rstAt, input int base);
    reqCyc = 0; reqAddr = '0; addrOk = 1; spurious = 0;
    repTr = '0; busyTr = '0; reqTr = '0; rstOuts = '1;
    obsQ.delete();
    Address = addr; L1IMiss = 1;
    @(posedge clk); #1; L1IMiss = hold;
    for (int i = 0; i <= ackDly; i++) begin
      MemAck = (i == ackDly); MemRdValid = gapped; MemRdData = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      if (MemReq) begin
        if (reqCyc > 0 && MemAddr !== reqAddr) addrOk = 0;
        reqAddr = MemAddr; reqCyc++;
      end
      if (RepReady) spurious = 1;
      @(posedge clk); #1;
    end
    MemAck = 0;
    for (int k = 0; k < BEATS; k++) begin
      if (gapped && k > 0) begin
        MemRdValid = 0;
        repeat (2) begin
          @(negedge clk); if (RepReady || MemReq) spurious = 1;
          @(posedge clk); #1;
        end
      end
      if (k == 3 && churn != 0) Address = churn;
      MemRdValid = 1; MemRdData = {32'((k + base) * (k + base)), 32'(k + base)};
      expQ.push_back(MemRdData);
      @(negedge clk); if (RepReady || MemReq) spurious = 1;
      @(posedge clk); #1;
    end
    MemRdValid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == rstAt) begin
        reset = 0; #1;
        rstOuts = {RepReady, RepWord, MemReq, MemAddr, RefillBusy};
        @(posedge clk); #1; reset = 1;
        return;
      end
      @(negedge clk);
      repTr[i] = RepReady; busyTr[i] = RefillBusy; reqTr[i] = MemReq;
      if (RepReady) obsQ.push_back(RepWord);
      @(posedge clk); #1;
      if (i == 8) L1IMiss = 0;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({RepReady, RepWord, MemReq, MemAddr, RefillBusy} !== '0) begin
      fails++; $display("FAIL reset_outs got %h exp 0", {RepReady, RepWord, MemReq, MemAddr, RefillBusy});
    end
    reset = 1;
    @(negedge clk);
    tests++;
    if ({RepReady, RepWord, MemReq, MemAddr, RefillBusy} !== '0) begin
      fails++; $display("FAIL idle_outs got %h exp 0", {RepReady, RepWord, MemReq, MemAddr, RefillBusy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [63:0] e, o;
    refill(32'h0000_1234, 0, 0, 0, 0, -1, 0);
    tests++; if (reqAddr !== 32'h0000_1200) begin fails++; $display("FAIL zw_addr got %h exp %h", reqAddr, 32'h0000_1200); end
    tests++; if (reqCyc !== 1) begin fails++; $display("FAIL zw_reqcyc got %0d exp 1", reqCyc); end
    tests++; if (repTr !== 16'h00FF) begin fails++; $display("FAIL zw_rep got %h exp 00ff", repTr); end
    tests++; if (busyTr !== 16'h01FF) begin fails++; $display("FAIL zw_busy got %h exp 01ff", busyTr); end
    tests++; if (spurious) begin fails++; $display("FAIL zw_spurious got 1 exp 0"); end
    tests++; if (obsQ.size() !== BEATS) begin fails++; $display("FAIL zw_count got %0d exp %0d", obsQ.size(), BEATS); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL zw_word got %h exp %h", o, e); end
    end
  endtask

  task automatic test_gapped();
    logic [63:0] e, o;
    refill(32'h0000_1234, 5, 1, 0, 0, -1, 0);
    tests++; if (reqAddr !== 32'h0000_1200) begin fails++; $display("FAIL gap_addr got %h exp %h", reqAddr, 32'h0000_1200); end
    tests++; if (reqCyc !== 6 || !addrOk) begin fails++; $display("FAIL gap_req got %0d/%0d exp 6/1", reqCyc, addrOk); end
    tests++; if (spurious) begin fails++; $display("FAIL gap_early got 1 exp 0"); end
    tests++; if (repTr !== 16'h00FF) begin fails++; $display("FAIL gap_rep got %h exp 00ff", repTr); end
    tests++; if (obsQ.size() !== BEATS) begin fails++; $display("FAIL gap_count got %0d exp %0d", obsQ.size(), BEATS); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL gap_word got %h exp %h", o, e); end
    end
  endtask

  task automatic test_held_miss();
    logic [63:0] e, o;
    refill(32'h0000_8000, 1, 0, 1, 0, -1, 11);
    tests++; if (reqCyc !== 2) begin fails++; $display("FAIL held_reqcyc got %0d exp 2", reqCyc); end
    tests++; if (reqTr !== 16'h0000 || spurious) begin fails++; $display("FAIL held_second_req got %h/%0d exp 0000/0", reqTr, spurious); end
    tests++; if (busyTr !== 16'h01FF) begin fails++; $display("FAIL held_busy got %h exp 01ff", busyTr); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL held_word got %h exp %h", o, e); end
    end
  endtask

  task automatic test_addr_churn();
    logic [63:0] e, o;
    refill(32'h0000_1234, 1, 0, 0, 32'hFFFF_FFC0, -1, 20);
    tests++; if (reqAddr !== 32'h0000_1200) begin fails++; $display("FAIL churn_addr got %h exp %h", reqAddr, 32'h0000_1200); end
    tests++; if (repTr !== 16'h00FF) begin fails++; $display("FAIL churn_rep got %h exp 00ff", repTr); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL churn_word got %h exp %h", o, e); end
    end
    refill(32'hFFFF_FFFF, 0, 0, 0, 0, -1, 30);
    tests++; if (reqAddr !== 32'hFFFF_FFC0) begin fails++; $display("FAIL churn_next_addr got %h exp %h", reqAddr, 32'hFFFF_FFC0); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL churn_next_word got %h exp %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [63:0] e, o;
    refill(32'h0000_1234, 0, 0, 0, 0, 3, 40);
    tests++; if (rstOuts !== '0) begin fails++; $display("FAIL rst_outs got %h exp 0", rstOuts); end
    tests++; if (obsQ.size() !== 3) begin fails++; $display("FAIL rst_partial got %0d exp 3", obsQ.size()); end
    for (int i = 0; i < 3; i++) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL rst_partial_word got %h exp %h", o, e); end
    end
    expQ.delete();
    MemRdValid = 1; MemRdData = 64'hBAD0_BAD0_BAD0_BAD0;
    refill(32'h0000_2240, 0, 0, 0, 0, -1, 60);
    tests++; if (reqAddr !== 32'h0000_2240 || reqCyc !== 1) begin fails++; $display("FAIL rst_restart got %h/%0d exp 00002240/1", reqAddr, reqCyc); end
    tests++; if (repTr !== 16'h00FF) begin fails++; $display("FAIL rst_rep got %h exp 00ff", repTr); end
    tests++; if (obsQ.size() !== BEATS) begin fails++; $display("FAIL rst_count got %0d exp %0d", obsQ.size(), BEATS); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.size() > 0 ? obsQ.pop_front() : 'x;
      tests++; if (o !== e) begin fails++; $display("FAIL rst_word got %h exp %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_gapped();
    test_held_miss();
    test_addr_churn();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
